station_sequencer: RTL



---
 rtl/station_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/station_sequencer.sv
// station_sequencer
//   Sequences one pass of the station. It debounces the trigger, averages
//   2^NSAMP_LOG2 XADC temperature samples and decides whether the station
//   is correct. On a correct station it then times the electromagnet grab,
//   the servo move, the release and the servo return, followed by a cooldown.
//
// Ports
//   CLK            system clock
//   reset          synchronous, active-high reset
//   trigger        station present (active-high), asynchronous to the pass
//   sampleReady    one-cycle pulse; digitalTemp is valid in that cycle
//   digitalTemp    12-bit XADC conversion result
//   sampleReq      request for XADC conversions, held high while sampling
//   correctStation latched decision of the last completed evaluation
//   avgTemp        latched average of the last completed evaluation
//   controlEM      electromagnet enable
//   controlServo   servo drive position select
//   busy           high in every state except IDLE
//   fault          sticky sample-timeout flag, cleared only by reset
//
// State      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for trigger
// DEBOUNCE   | trigger must stay high for DEBOUNCE_CYC cycles
// SAMPLE     | request and accumulate samples, watch the timeout
// EVAL       | latch average and decision (one cycle)
// GRAB       | EM on, servo home
// MOVE       | EM on, servo moved
// RELEASE    | EM off, servo still moved
// RETURN     | EM off, servo back home
// COOLDOWN   | dead time, trigger ignored
module station_sequencer #(
  parameter int          DEBOUNCE_CYC   = 1000,
  parameter int          NSAMP_LOG2     = 2,
  parameter int          SAMPLE_TIMEOUT = 100000,
  parameter logic [11:0] TEMP_LO        = 12'h600,
  parameter logic [11:0] TEMP_HI        = 12'h900,
  parameter int          GRAB_CYC       = 5000,
  parameter int          MOVE_CYC       = 20000,
  parameter int          RELEASE_CYC    = 5000,
  parameter int          COOLDOWN_CYC   = 10000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        trigger,
  input  logic        sampleReady,
  input  logic [11:0] digitalTemp,
  output logic        sampleReq,
  output logic        correctStation,
  output logic [11:0] avgTemp,
  output logic        controlEM,
  output logic        controlServo,
  output logic        busy,
  output logic        fault
);

  // One phase timer is shared by all timed states, so it is sized for the longest.
  localparam int TMAX_A = (DEBOUNCE_CYC > GRAB_CYC) ? DEBOUNCE_CYC : GRAB_CYC;
  localparam int TMAX_B = (MOVE_CYC > RELEASE_CYC) ? MOVE_CYC : RELEASE_CYC;
  localparam int TMAX_C = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TMAX   = (TMAX_C > COOLDOWN_CYC) ? TMAX_C : COOLDOWN_CYC;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int OW     = $clog2(SAMPLE_TIMEOUT + 1);
  localparam int ACW    = 12 + NSAMP_LOG2;

  typedef enum logic [3:0] {
    S_IDLE, S_DEBOUNCE, S_SAMPLE, S_EVAL, S_GRAB,
    S_MOVE, S_RELEASE, S_RETURN, S_COOLDOWN
  } state_t;

  state_t                state, state_nxt;
  logic [TW-1:0]         timer, timer_nxt;
  logic [OW-1:0]         tmo, tmo_nxt;
  logic [NSAMP_LOG2-1:0] scnt, scnt_nxt;
  logic [ACW-1:0]        acc, acc_nxt;
  logic [11:0]           avg_calc, avg_nxt;
  logic                  correct_nxt, fault_nxt;
  logic                  req_nxt, em_nxt, servo_nxt, busy_nxt;

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    tmo_nxt     = tmo;
    scnt_nxt    = scnt;
    acc_nxt     = acc;
    avg_nxt     = avgTemp;
    correct_nxt = correctStation;
    fault_nxt   = fault;
    avg_calc    = 12'(acc >> NSAMP_LOG2);

    case (state)
      S_IDLE: begin
        if (trigger) begin
          state_nxt = S_DEBOUNCE;
          timer_nxt = TW'(DEBOUNCE_CYC - 1);
        end
      end
      S_DEBOUNCE: begin
        if (!trigger) begin
          state_nxt = S_IDLE;
        end else if (timer == '0) begin
          state_nxt = S_SAMPLE;
          acc_nxt   = '0;
          scnt_nxt  = '1;
          tmo_nxt   = OW'(SAMPLE_TIMEOUT - 1);
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      S_SAMPLE: begin
        // A sample arriving on the expiry cycle wins over the timeout.
        if (sampleReady && sampleReq) begin
          acc_nxt = acc + ACW'(digitalTemp);
          tmo_nxt = OW'(SAMPLE_TIMEOUT - 1);
          if (scnt == '0) state_nxt = S_EVAL;
          else            scnt_nxt  = scnt - NSAMP_LOG2'(1);
        end else if (tmo == '0) begin
          fault_nxt = 1'b1;
          state_nxt = S_COOLDOWN;
          timer_nxt = TW'(COOLDOWN_CYC - 1);
        end else begin
          tmo_nxt = tmo - OW'(1);
        end
      end
      S_EVAL: begin
        avg_nxt     = avg_calc;
        correct_nxt = (avg_calc >= TEMP_LO) && (avg_calc <= TEMP_HI);
        if (correct_nxt) begin
          state_nxt = S_GRAB;
          timer_nxt = TW'(GRAB_CYC - 1);
        end else begin
          state_nxt = S_COOLDOWN;
          timer_nxt = TW'(COOLDOWN_CYC - 1);
        end
      end
      S_GRAB, S_MOVE, S_RELEASE, S_RETURN, S_COOLDOWN: begin
        if (timer != '0) begin
          timer_nxt = timer - TW'(1);
        end else begin
          case (state)
            S_GRAB:    begin state_nxt = S_MOVE;     timer_nxt = TW'(MOVE_CYC - 1);     end
            S_MOVE:    begin state_nxt = S_RELEASE;  timer_nxt = TW'(RELEASE_CYC - 1);  end
            S_RELEASE: begin state_nxt = S_RETURN;   timer_nxt = TW'(MOVE_CYC - 1);     end
            S_RETURN:  begin state_nxt = S_COOLDOWN; timer_nxt = TW'(COOLDOWN_CYC - 1); end
            default:   state_nxt = S_IDLE;
          endcase
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Outputs are registered from the next state so they switch on entry.
    req_nxt   = (state_nxt == S_SAMPLE);
    em_nxt    = (state_nxt == S_GRAB) || (state_nxt == S_MOVE);
    servo_nxt = (state_nxt == S_MOVE) || (state_nxt == S_RELEASE);
    busy_nxt  = (state_nxt != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state          <= S_IDLE;
      timer          <= '0;
      tmo            <= '0;
      scnt           <= '0;
      acc            <= '0;
      avgTemp        <= '0;
      correctStation <= 1'b0;
      fault          <= 1'b0;
      sampleReq      <= 1'b0;
      controlEM      <= 1'b0;
      controlServo   <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      timer          <= timer_nxt;
      tmo            <= tmo_nxt;
      scnt           <= scnt_nxt;
      acc            <= acc_nxt;
      avgTemp        <= avg_nxt;
      correctStation <= correct_nxt;
      fault          <= fault_nxt;
      sampleReq      <= req_nxt;
      controlEM      <= em_nxt;
      controlServo   <= servo_nxt;
      busy           <= busy_nxt;
    end
  end

endmodule
